// File: rtl/alu_sequencer.sv
// Issues one 8-bit instruction to a registered ALU and writes the result back, 3 cycles accept-to-accept.
// Backpressure: instr_ready is low from accept until write-back; instructions offered meanwhile are ignored.
module alu_sequencer #(
  parameter int         DW     = 8,
  parameter logic [2:0] OP_LDI = 3'b111
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [7:0]    instr,
  input  logic [DW-1:0] imm,
  output logic          alu_en,
  output logic [2:0]    alu_op,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_zero,
  input  logic          alu_carry,
  output logic          done,
  output logic [DW-1:0] result,
  output logic          zero,
  output logic          carry,
  input  logic [1:0]    dbg_addr,
  output logic [DW-1:0] dbg_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPT} state_t;

  state_t        state_q, state_d;
  logic [7:1]    instr_q, instr_d;
  logic [DW-1:0] imm_q, imm_d;
  logic [DW-1:0] rf_q [4];
  logic [DW-1:0] rf_d [4];
  logic [DW-1:0] result_q, result_d;
  logic          zero_q, zero_d;
  logic          carry_q, carry_d;
  logic          done_q, done_d;
  logic          alu_en_q, alu_en_d;
  logic          ready_q, ready_d;

  logic [2:0] op;
  logic [1:0] rd, rs;
  logic       unused_rsvd;

  // instr[0] is reserved and deliberately never latched
  assign unused_rsvd = instr[0];

  assign op = instr_q[7:5];
  assign rd = instr_q[4:3];
  assign rs = instr_q[2:1];

  assign instr_ready = ready_q;
  assign alu_en      = alu_en_q;
  assign alu_op      = op;
  assign alu_a       = rf_q[rd];
  assign alu_b       = rf_q[rs];
  assign done        = done_q;
  assign result      = result_q;
  assign zero        = zero_q;
  assign carry       = carry_q;
  assign dbg_data    = rf_q[dbg_addr];

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    imm_d    = imm_q;
    rf_d     = rf_q;
    result_d = result_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    done_d   = 1'b0;
    alu_en_d = 1'b0;
    ready_d  = ready_q;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (instr_valid) begin
          instr_d  = instr[7:1];
          imm_d    = imm;
          alu_en_d = (instr[7:5] != OP_LDI);
          ready_d  = 1'b0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        state_d = CAPT;
      end
      CAPT: begin
        // LDI bypasses the ALU and leaves the flags untouched
        if (op == OP_LDI) begin
          rf_d[rd] = imm_q;
          result_d = imm_q;
        end else begin
          rf_d[rd] = alu_out;
          result_d = alu_out;
          zero_d   = alu_zero;
          carry_d  = alu_carry;
        end
        done_d  = 1'b1;
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      instr_q  <= '0;
      imm_q    <= '0;
      for (int i = 0; i < 4; i++) rf_q[i] <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      done_q   <= 1'b0;
      alu_en_q <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      imm_q    <= imm_d;
      rf_q     <= rf_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      done_q   <= done_d;
      alu_en_q <= alu_en_d;
      ready_q  <= ready_d;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a registered ALU model and a result scoreboard.
module tb_alu_sequencer;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [7:0]    instr = '0;
  logic [DW-1:0] imm = '0;
  logic          alu_en;
  logic [2:0]    alu_op;
  logic [DW-1:0] alu_a, alu_b;
  logic [DW-1:0] alu_out = '0;
  logic          alu_zero = 1'b0;
  logic          alu_carry = 1'b0;
  logic          done;
  logic [DW-1:0] result;
  logic          zero, carry;
  logic [1:0]    dbg_addr = '0;
  logic [DW-1:0] dbg_data;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] res;
    logic       z;
    logic       c;
    logic [1:0] rd;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] ref_r [4];
  logic       ref_z, ref_c;

  alu_sequencer dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .imm(imm),
    .alu_en(alu_en), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .done(done), .result(result), .zero(zero), .carry(carry),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // returns {zero, carry, result}
  function automatic logic [9:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    case (op)
      3'd0:    s = {1'b0, a} + {1'b0, b};
      3'd1:    s = {1'b0, a} - {1'b0, b};
      3'd2:    s = {1'b0, a} + 9'd1;
      3'd3:    s = {1'b0, a} - 9'd1;
      3'd4:    s = {1'b0, a & b};
      3'd5:    s = {1'b0, a | b};
      3'd6:    s = {1'b0, a ^ b};
      default: s = '0;
    endcase
    return {s[7:0] == 8'h00, s[8], s[7:0]};
  endfunction

  always @(posedge clk) begin
    if (alu_en) {alu_zero, alu_carry, alu_out} <= alu_f(alu_op, alu_a, alu_b);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_ref();
    for (int i = 0; i < 4; i++) ref_r[i] = '0;
    ref_z = 1'b0;
    ref_c = 1'b0;
    sbq.delete();
  endtask

  task automatic push_exp(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs, input logic [7:0] im);
    exp_t e;
    if (op == 3'd7) begin
      e.res = im;
      e.z   = ref_z;
      e.c   = ref_c;
    end else begin
      {e.z, e.c, e.res} = alu_f(op, ref_r[rd], ref_r[rs]);
    end
    e.rd      = rd;
    ref_r[rd] = e.res;
    ref_z     = e.z;
    ref_c     = e.c;
    sbq.push_back(e);
  endtask

  task automatic check_done();
    exp_t e;
    chk("sb_nonempty", 32'(sbq.size() != 0), 1);
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      chk("result", result, e.res);
      chk("zero", zero, e.z);
      chk("carry", carry, e.c);
      dbg_addr = e.rd;
      #1;
      chk("dbg_wb", dbg_data, e.res);
    end
  endtask

  task automatic exec(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs, input logic [7:0] im);
    int n, edges, en_cnt;
    logic acc, got;
    logic [7:0] old, ea, eb, sa, sb;
    ea = ref_r[rd]; eb = ref_r[rs]; old = ref_r[rd];
    instr = {op, rd, rs, 1'($urandom)};
    imm = im;
    instr_valid = 1'b1;
    dbg_addr = rd;
    n = 0;
    forever begin
      acc = instr_ready;
      @(posedge clk); #1; n++;
      if (acc || n >= 20) break;
    end
    instr_valid = 1'b0;
    instr = 8'($urandom);
    imm = 8'($urandom);
    chk("accept", acc, 1);
    if (acc) push_exp(op, rd, rs, im);
    edges = 0; en_cnt = 0; got = 1'b0; sa = '0; sb = '0;
    while (!got && edges < 10) begin
      @(negedge clk);
      if (alu_en) begin en_cnt++; sa = alu_a; sb = alu_b; end
      if (edges == 1) chk("dbg_old", dbg_data, old);
      if (done) got = 1'b1;
      else begin @(posedge clk); #1; edges++; end
    end
    chk("done_seen", got, 1);
    chk("latency", edges, 2);
    chk("alu_en_cycles", en_cnt, (op == 3'd7) ? 0 : 1);
    if (op != 3'd7) begin
      chk("alu_a", sa, ea);
      chk("alu_b", sb, eb);
    end
    if (got) check_done();
  endtask

  initial begin
    logic [2:0] p_op [4];
    logic [1:0] p_rd [4];
    logic [1:0] p_rs [4];
    logic [7:0] p_im [4];
    int idx, acc_cnt, done_cnt, last_acc, dcnt;
    logic acc;

    reset_ref();
    #17 rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1;
      chk("rst_rf", dbg_data, 0);
    end
    chk("rst_ready", instr_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_zero", zero, 0);
    chk("rst_carry", carry, 0);
    chk("rst_alu_en", alu_en, 0);
    chk("rst_result", result, 0);

    exec(3'd7, 2'd1, 2'd0, 8'hF0);
    exec(3'd7, 2'd2, 2'd0, 8'h20);
    exec(3'd0, 2'd1, 2'd2, 8'h00);
    exec(3'd7, 2'd0, 2'd0, 8'h05);
    exec(3'd1, 2'd0, 2'd0, 8'h00);
    exec(3'd3, 2'd0, 2'd3, 8'h00);
    exec(3'd7, 2'd3, 2'd0, 8'hAA);
    exec(3'd7, 2'd2, 2'd0, 8'h0F);
    exec(3'd6, 2'd3, 2'd2, 8'h00);
    exec(3'd2, 2'd2, 2'd1, 8'h00);
    exec(3'd4, 2'd3, 2'd2, 8'h00);
    exec(3'd5, 2'd3, 2'd1, 8'h00);

    // back-to-back stream with instr_valid held high and junk while not ready
    p_op = '{3'd7, 3'd2, 3'd0, 3'd7};
    p_rd = '{2'd0, 2'd0, 2'd0, 2'd1};
    p_rs = '{2'd0, 2'd0, 2'd0, 2'd0};
    p_im = '{8'h7F, 8'h00, 8'h00, 8'h33};
    idx = 0; acc_cnt = 0; done_cnt = 0; last_acc = -1;
    for (int cyc = 0; cyc < 40 && done_cnt < 4; cyc++) begin
      @(negedge clk);
      if (done) begin done_cnt++; check_done(); end
      if (idx < 4) begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          instr = {p_op[idx], p_rd[idx], p_rs[idx], 1'b1};
          imm = p_im[idx];
          push_exp(p_op[idx], p_rd[idx], p_rs[idx], p_im[idx]);
          if (last_acc >= 0) chk("b2b_gap", cyc - last_acc, 3);
          last_acc = cyc;
          acc_cnt++;
          idx++;
        end else begin
          instr = 8'($urandom);
          imm = 8'($urandom);
        end
      end else begin
        if (!instr_ready) instr_valid = 1'b0;
        instr = 8'($urandom);
      end
    end
    instr_valid = 1'b0;
    chk("b2b_accepts", acc_cnt, 4);
    chk("b2b_dones", done_cnt, 4);
    chk("b2b_sb_empty", sbq.size(), 0);

    // reset during ISSUE aborts the instruction
    @(negedge clk);
    instr = {3'd0, 2'd1, 2'd2, 1'b0};
    instr_valid = 1'b1;
    dcnt = 0;
    forever begin
      acc = instr_ready;
      @(posedge clk); #1; dcnt++;
      if (acc || dcnt >= 20) break;
    end
    instr_valid = 1'b0;
    chk("abort_accept", acc, 1);
    #1;
    chk("abort_en_before", alu_en, 1);
    rst = 1'b0;
    #1;
    chk("abort_en_async", alu_en, 0);
    chk("abort_done_async", done, 0);
    chk("abort_ready_async", instr_ready, 1);
    #20 rst = 1'b1;
    reset_ref();
    dcnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("abort_no_done", dcnt, 0);
    chk("abort_ready", instr_ready, 1);
    chk("abort_result", result, 0);
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1;
      chk("abort_rf", dbg_data, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Issue controller for the CPU's registered ALU (1-cycle latency, registered out/flag_zero/flag_carry, enable-gated).
- Accepts 8-bit instructions over a valid/ready handshake and reads operands from an internal 4-entry register file.
- Drives the ALU en/operation/a/b inputs, captures the result one cycle later, and writes it back.
- Publishes result, flags and a completion pulse to the fetch/decode logic.

Parameters:
- DW, 8, datapath width (register, operand and immediate width).
- OP_LDI, 3'b111, opcode for the load-immediate instruction, which bypasses the ALU.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- instr_valid  input  1  instruction offered.
- instr_ready  output  1  sequencer can accept an instruction.
- instr  input  8  [7:5] op, [4:3] rd, [2:1] rs, [0] reserved (ignored).
- imm  input  DW  immediate, used only by OP_LDI.
- alu_en  output  1  ALU enable.
- alu_op  output  3  ALU operation code.
- alu_a  output  DW  ALU operand a = R[rd].
- alu_b  output  DW  ALU operand b = R[rs].
- alu_out  input  DW  ALU registered result.
- alu_zero  input  1  ALU registered zero flag.
- alu_carry  input  1  ALU registered carry/borrow flag.
- done  output  1  one-cycle completion pulse.
- result  output  DW  last written-back value.
- zero  output  1  architectural zero flag.
- carry  output  1  architectural carry flag.
- dbg_addr  input  2  debug register-file read address.
- dbg_data  output  DW  R[dbg_addr], combinational.

Behaviour:
- Opcodes: 0 ADD, 1 SUB, 2 INC, 3 DEC, 4 AND, 5 OR, 6 XOR, 7 LDI.
  - alu_op = op for opcodes 0-6.
  - INC/DEC ignore rs; alu_b is still driven with R[rs].
- Reset (rst=0, asynchronous):
  - state=IDLE; R[0..3]=0; result=0; zero=0; carry=0; done=0.
  - Latched instruction and immediate cleared.
  - alu_en=0; alu_op/alu_a/alu_b = 0 (they follow cleared registers).
  - A reset mid-instruction aborts it: no write-back, no done.
- FSM states: IDLE -> ISSUE -> CAPT -> IDLE.
- IDLE:
  - instr_ready=1.
  - On instr_valid=1, latch instr and imm at the clock edge and go to ISSUE.
  - Otherwise hold.
- ISSUE (1 cycle):
  - instr_ready=0.
  - For ALU ops: alu_en=1, alu_op=op, alu_a=R[rd], alu_b=R[rs]. Operands come from the register file at this cycle.
  - For LDI: alu_en=0.
  - Go to CAPT.
- CAPT (1 cycle):
  - instr_ready=0; alu_en=0.
  - At the clock edge for ALU ops: R[rd]<=alu_out, result<=alu_out, zero<=alu_zero, carry<=alu_carry.
  - At the clock edge for LDI: R[rd]<=imm, result<=imm; zero and carry unchanged.
  - done<=1 for exactly one cycle. Go to IDLE.
- Latency and throughput:
  - Accept edge T0, ALU capture edge T1, write-back edge T2.
  - done is high T2..T3, with result/zero/carry already updated.
  - instr_ready is high from T2, so the next instruction can be accepted at edge T3.
  - Throughput is one instruction per 3 cycles.
- Hazards:
  - None possible, since there is no overlap.
  - An instruction accepted while done is high reads the freshly written R[rd].
- Widths and flags:
  - All register-file and operand paths are DW bits.
  - Flags are taken verbatim from the ALU: carry = bit DW of the add, borrow for SUB/DEC, 0 for logic ops.
  - The sequencer does not recompute flags.
- Debug port:
  - dbg_data reads combinationally.
  - During the write-back cycle it returns the old value until the edge.
- instr_valid while not in IDLE is ignored, not queued. The sender must hold the instruction until handshake.
- Reserved bit instr[0] has no effect.

Test Plan:
- Reset then debug reads of 0..3 -> all 0. instr_ready=1, done=0, zero=0, carry=0.
- LDI r1,0xF0; LDI r2,0x20; ADD r1,r2 -> alu_en high exactly one cycle with a=0xF0, b=0x20. done at the third cycle after accept. result=0x10, carry=1, zero=0, R1=0x10.
- LDI r0,0x05; SUB r0,r0 -> result=0x00, zero=1, carry=0. Then DEC r0 -> result=0xFF, carry=1, zero=0.
- LDI r3,0xAA; LDI r2,0x0F; XOR r3,r2 -> result=0xA5, carry=0. The LDIs leave zero/carry at their prior values.
- Back-to-back: instr_valid held continuously with 4 instructions -> accepts exactly every 3 cycles; 4 done pulses; instr changes while not ready are ignored.
- Assert rst during ISSUE of ADD r1,r2 -> no done, R1=0 after reset, state IDLE, alu_en=0 immediately (asynchronously).
